commutation_control: RTL and testbench
======================================

COMMUTATION_CONTROL -- requirements
Module: commutation_control

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of input synchronizer flops on UI and HS, legal range 0-3.
REQ-002 SHALL have parameter DEAD_CYCLES, default 1: number of all-off clock cycles inserted between conflicting drive patterns, legal range 0-15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 UI  input  3  user command: UI[2]=CW, UI[1]=CCW, UI[0]=regen brake one.
REQ-006 HS  input  3  Hall sensors {HA,HB,HC}; asynchronous to clk.
REQ-007 PT  output  6  gate drives {AH,AL,BH,BL,CH,CL} (PT[5]..PT[0]); 1 = transistor on; registered.

Function
REQ-008 Hall decode SHALL map HS to sector: 100=S1, 110=S2, 010=S3, 011=S4, 001=S5, 101=S6; 000 and 111 are invalid.
REQ-009 Mode decode SHALL be: 000=OFF, 100=CW, 010=CCW, 110=BRAKE2, 001=BRAKE1; every other UI code (011, 101, 111) is OFF.
REQ-010 CW drive SHALL be: S1=AH+BL (100100), S2=AH+CL (100001), S3=BH+CL (001001), S4=BH+AL (011000), S5=CH+AL (010010), S6=CH+BL (000110).
REQ-011 CCW drive SHALL be: S1=BH+AL (011000), S2=CH+AL (010010), S3=CH+BL (000110), S4=AH+BL (100100), S5=AH+CL (100001), S6=BH+CL (001001).
REQ-012 BRAKE2 SHALL turn on all three low-side switches (010101) in every valid sector.
REQ-013 BRAKE1 SHALL turn on the low sides of the two phases that CW energizes in that sector: S1/S4=AL+BL (010100), S2/S5=AL+CL (010001), S3/S6=BL+CL (000101).
REQ-014 OFF mode or an invalid Hall code SHALL produce PT=000000 in every mode.
REQ-015 The target pattern SHALL be computed combinationally from the synchronized UI and HS values.
REQ-016 PT SHALL be registered, with latency SYNC_STAGES+1 cycles from an input change to PT when no dead time applies.
REQ-017 If the new target turns on any switch that is off in the current PT, and the current PT is nonzero: PT SHALL go to 000000 for DEAD_CYCLES cycles, then load the target present at the end of the gap.
REQ-018 Targets that only remove switches, and all transitions from 000000, SHALL load with no gap.
REQ-019 A target change during a gap SHALL restart the gap counter, and PT SHALL stay 000000.
REQ-020 PT SHALL never assert both AH and AL, BH and BL, or CH and CL in the same cycle, including during gaps and reset.
REQ-021 With DEAD_CYCLES=0, PT SHALL equal the registered target each cycle.

Reset
REQ-022 rst_n low SHALL force PT=000000 immediately, independent of clk.
REQ-023 rst_n low SHALL clear the synchronizer flops to 000 and the gap counter to 0.
REQ-024 After rst_n deasserts, the first nonzero target SHALL load without a gap (REQ-018).
REQ-025 Reset asserted mid-gap or mid-drive SHALL abort to the reset state with no residual drive.

Structure
REQ-026 Package commutation_pkg SHALL hold the Hall sector codes, the mode enum (OFF, CW, CCW, BRAKE1, BRAKE2), the PT bit indices and the PT pattern constants.
REQ-027 Dead-time insertion SHALL be one sub-module, commutation_dead_time, taking the target and producing the registered PT.
REQ-028 The top level SHALL hold the synchronizers, the mode and Hall decode, and the target lookup.

Verification
REQ-029 UI=000 with HS stepping through S1..S6, each held 10 cycles -> PT=000000 throughout.
REQ-030 UI=100 with HS stepping S6,S5,S4,S3,S2,S1 -> after each settle PT = 000110, 010010, 011000, 001001, 100001, 100100, with an all-off gap of DEAD_CYCLES cycles at each step.
REQ-031 UI=010 with HS stepping S1..S6 -> PT = 011000, 010010, 000110, 100100, 100001, 001001.
REQ-032 UI=110 in every sector -> PT=010101; UI=001 in S1 -> PT=010100, in S2 -> 010001, in S3 -> 000101.
REQ-033 UI=111, 101 or 011 in every sector, and HS=000 or 111 in any mode -> PT=000000.
REQ-034 Assert rst_n low asynchronously while PT=100100 -> PT=000000 before the next clk edge; a checker enforces REQ-020 on every cycle of every scenario.

Source files
------------

// File: rtl/commutation_pkg.sv
// Shared types and constants for the BLDC six-step commutation controller:
// Hall sector codes, drive modes, gate-drive bit positions and patterns.
package commutation_pkg;

  typedef enum logic [2:0] {
    MODE_OFF,
    MODE_CW,
    MODE_CCW,
    MODE_BRAKE1,
    MODE_BRAKE2
  } mode_e;

  typedef enum logic [2:0] {
    SEC_NONE,
    SEC_1,
    SEC_2,
    SEC_3,
    SEC_4,
    SEC_5,
    SEC_6
  } sector_e;

  typedef enum logic {
    DT_RUN,
    DT_GAP
  } dt_state_e;

  // Hall codes {HA,HB,HC}
  localparam logic [2:0] HALL_S1 = 3'b100;
  localparam logic [2:0] HALL_S2 = 3'b110;
  localparam logic [2:0] HALL_S3 = 3'b010;
  localparam logic [2:0] HALL_S4 = 3'b011;
  localparam logic [2:0] HALL_S5 = 3'b001;
  localparam logic [2:0] HALL_S6 = 3'b101;

  // PT bit positions {AH,AL,BH,BL,CH,CL}
  localparam int unsigned PT_AH = 5;
  localparam int unsigned PT_AL = 4;
  localparam int unsigned PT_BH = 3;
  localparam int unsigned PT_BL = 2;
  localparam int unsigned PT_CH = 1;
  localparam int unsigned PT_CL = 0;

  localparam logic [5:0] PT_OFF     = 6'b000000;
  localparam logic [5:0] PT_AH_BL   = 6'b100100;
  localparam logic [5:0] PT_AH_CL   = 6'b100001;
  localparam logic [5:0] PT_BH_CL   = 6'b001001;
  localparam logic [5:0] PT_BH_AL   = 6'b011000;
  localparam logic [5:0] PT_CH_AL   = 6'b010010;
  localparam logic [5:0] PT_CH_BL   = 6'b000110;
  localparam logic [5:0] PT_ALL_LOW = 6'b010101;
  localparam logic [5:0] PT_AL_BL   = 6'b010100;
  localparam logic [5:0] PT_AL_CL   = 6'b010001;
  localparam logic [5:0] PT_BL_CL   = 6'b000101;

endpackage

// File: rtl/commutation_dead_time.sv
// Registers the gate-drive target, inserting an all-off gap whenever the
// new pattern would switch on a transistor while another is still driven.
module commutation_dead_time
  import commutation_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] target,
  output logic [5:0] pt
);

  localparam logic [3:0] GAP_LEN = 4'(DEAD_CYCLES);

  dt_state_e  state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [5:0] pend, pend_next;
  logic [5:0] pt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DT_RUN;
      cnt   <= '0;
      pend  <= '0;
      pt    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pend  <= pend_next;
      pt    <= pt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_next  = pend;
    pt_next    = pt;
    unique case (state)
      DT_RUN: begin
        if (target != pt) begin
          if (GAP_LEN != '0 && pt != PT_OFF && (target & ~pt) != PT_OFF) begin
            state_next = DT_GAP;
            cnt_next   = GAP_LEN;
            pend_next  = target;
            pt_next    = PT_OFF;
          end else begin
            pt_next = target;
          end
        end
      end
      DT_GAP: begin
        // A moving target restarts the full gap; PT stays off meanwhile.
        if (target != pend) begin
          pend_next = target;
          cnt_next  = GAP_LEN;
        end else if (cnt == 4'd1) begin
          state_next = DT_RUN;
          cnt_next   = '0;
          pt_next    = target;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = DT_RUN;
    endcase
  end

endmodule

// File: rtl/commutation_control.sv
// Six-step BLDC commutation: synchronizes user command and Hall inputs,
// decodes mode and sector, looks up the drive pattern and applies dead time.
module commutation_control
  import commutation_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] UI,
  input  logic [2:0] HS,
  output logic [5:0] PT
);

  logic [2:0] ui_sync, hs_sync;
  mode_e      mode;
  sector_e    sector;
  logic [5:0] target;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign ui_sync = UI;
    assign hs_sync = HS;
  end else begin : g_sync
    logic [5:0] pipe [SYNC_STAGES];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= {UI, HS};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign {ui_sync, hs_sync} = pipe[SYNC_STAGES-1];
  end

  always_comb begin
    mode = MODE_OFF;
    unique case (ui_sync)
      3'b100:  mode = MODE_CW;
      3'b010:  mode = MODE_CCW;
      3'b110:  mode = MODE_BRAKE2;
      3'b001:  mode = MODE_BRAKE1;
      default: mode = MODE_OFF;
    endcase
  end

  always_comb begin
    sector = SEC_NONE;
    unique case (hs_sync)
      HALL_S1: sector = SEC_1;
      HALL_S2: sector = SEC_2;
      HALL_S3: sector = SEC_3;
      HALL_S4: sector = SEC_4;
      HALL_S5: sector = SEC_5;
      HALL_S6: sector = SEC_6;
      default: sector = SEC_NONE;
    endcase
  end

  always_comb begin
    target = PT_OFF;
    if (sector != SEC_NONE) begin
      unique case (mode)
        MODE_CW: begin
          unique case (sector)
            SEC_1:   target = PT_AH_BL;
            SEC_2:   target = PT_AH_CL;
            SEC_3:   target = PT_BH_CL;
            SEC_4:   target = PT_BH_AL;
            SEC_5:   target = PT_CH_AL;
            SEC_6:   target = PT_CH_BL;
            default: target = PT_OFF;
          endcase
        end
        MODE_CCW: begin
          unique case (sector)
            SEC_1:   target = PT_BH_AL;
            SEC_2:   target = PT_CH_AL;
            SEC_3:   target = PT_CH_BL;
            SEC_4:   target = PT_AH_BL;
            SEC_5:   target = PT_AH_CL;
            SEC_6:   target = PT_BH_CL;
            default: target = PT_OFF;
          endcase
        end
        MODE_BRAKE2: target = PT_ALL_LOW;
        MODE_BRAKE1: begin
          unique case (sector)
            SEC_1, SEC_4: target = PT_AL_BL;
            SEC_2, SEC_5: target = PT_AL_CL;
            SEC_3, SEC_6: target = PT_BL_CL;
            default:      target = PT_OFF;
          endcase
        end
        default: target = PT_OFF;
      endcase
    end
  end

  commutation_dead_time #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_dead_time (
    .clk   (clk),
    .rst_n (rst_n),
    .target(target),
    .pt    (PT)
  );

endmodule

// File: tb/tb_commutation_control.sv
// Randomized and directed bench for commutation_control against a
// table-driven reference model of synchronizer delay, lookup and dead time.
module tb_commutation_control;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEAD = 2;

  localparam logic [2:0] HALL_SEQ [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  localparam logic [5:0] CW_TAB   [6] = '{6'b100100, 6'b100001, 6'b001001,
                                          6'b011000, 6'b010010, 6'b000110};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ui, hs;
  logic [5:0] pt;

  int checks = 0;
  int failures = 0;
  int zero_cycles;

  logic [5:0] m_line [$];
  logic [5:0] m_pt, m_gap_tgt;
  int         m_gap_left;

  commutation_control #(
    .SYNC_STAGES(SYNC),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .UI   (ui),
    .HS   (hs),
    .PT   (pt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  always @(negedge clk) check_eq("shoot_through", (pt & (pt >> 1)) & 6'b010101, 6'b000000);

  function automatic logic [5:0] ref_target(input logic [2:0] u, input logic [2:0] h);
    int s = -1;
    for (int i = 0; i < 6; i++) if (h == HALL_SEQ[i]) s = i;
    if (s < 0) return 6'b000000;
    case (u)
      3'b100:  return CW_TAB[s];
      3'b010:  return CW_TAB[(s + 3) % 6];
      3'b110:  return 6'b010101;
      3'b001:  return (CW_TAB[s] | (CW_TAB[s] >> 1)) & 6'b010101;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic model_reset();
    m_line.delete();
    for (int i = 0; i < int'(SYNC); i++) m_line.push_back(6'b000000);
    m_pt = '0;
    m_gap_tgt = '0;
    m_gap_left = 0;
  endtask

  task automatic model_step();
    logic [5:0] src, tgt;
    if (SYNC == 0) src = {ui, hs};
    else begin
      src = m_line.pop_front();
      m_line.push_back({ui, hs});
    end
    tgt = ref_target(src[5:3], src[2:0]);
    if (m_gap_left > 0) begin
      if (tgt != m_gap_tgt) begin
        m_gap_tgt = tgt;
        m_gap_left = DEAD;
      end else begin
        m_gap_left--;
        if (m_gap_left == 0) m_pt = tgt;
      end
    end else if (tgt != m_pt) begin
      if (DEAD > 0 && m_pt != 0 && (tgt & ~m_pt) != 0) begin
        m_pt = '0;
        m_gap_left = DEAD;
        m_gap_tgt = tgt;
      end else m_pt = tgt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_eq("pt_model", pt, m_pt);
    if (pt == 6'b000000) zero_cycles++;
  endtask

  task automatic hold(input logic [2:0] u, input logic [2:0] h, input int n);
    ui = u;
    hs = h;
    zero_cycles = 0;
    repeat (n) tick();
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", pt, 6'b000000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [5:0] cw_exp  [5] = '{6'b010010, 6'b011000, 6'b001001, 6'b100001, 6'b100100};
    logic [5:0] ccw_exp [6] = '{6'b011000, 6'b010010, 6'b000110, 6'b100100, 6'b100001, 6'b001001};
    logic [5:0] b1_exp  [3] = '{6'b010100, 6'b010001, 6'b000101};
    logic [2:0] bad_ui  [3] = '{3'b111, 3'b101, 3'b011};
    logic [2:0] modes   [4] = '{3'b100, 3'b010, 3'b110, 3'b001};
    logic [2:0] bad_hs  [2] = '{3'b000, 3'b111};

    rst_n = 1'b0;
    ui = '0;
    hs = '0;
    model_reset();
    #3 check_eq("reset_pt", pt, 6'b000000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      hold(3'b000, HALL_SEQ[i], 10);
      check_eq("off_mode", pt, 6'b000000);
    end

    hold(3'b100, HALL_SEQ[5], 10);
    check_eq("cw_s6", pt, 6'b000110);
    for (int i = 4; i >= 0; i--) begin
      hold(3'b100, HALL_SEQ[i], 10);
      check_eq("cw_step", pt, cw_exp[4 - i]);
      check_eq("cw_gap_len", 6'(zero_cycles), 6'(DEAD));
    end

    for (int i = 0; i < 6; i++) begin
      hold(3'b010, HALL_SEQ[i], 10);
      check_eq("ccw_step", pt, ccw_exp[i]);
    end

    for (int i = 0; i < 6; i++) begin
      hold(3'b110, HALL_SEQ[i], 10);
      check_eq("brake2", pt, 6'b010101);
    end
    for (int i = 0; i < 3; i++) begin
      hold(3'b001, HALL_SEQ[i], 10);
      check_eq("brake1", pt, b1_exp[i]);
    end

    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 6; i++) begin
        hold(bad_ui[u], HALL_SEQ[i], 6);
        check_eq("bad_ui", pt, 6'b000000);
      end
    for (int m = 0; m < 4; m++)
      for (int h = 0; h < 2; h++) begin
        hold(modes[m], bad_hs[h], 6);
        check_eq("bad_hall", pt, 6'b000000);
      end

    hold(3'b100, HALL_SEQ[0], 10);
    check_eq("cw_before_reset", pt, 6'b100100);
    reset_pulse();
    hold(3'b100, HALL_SEQ[0], 10);
    check_eq("post_reset_latency", 6'(zero_cycles), 6'(SYNC));
    check_eq("post_reset_pt", pt, 6'b100100);

    hold(3'b100, HALL_SEQ[1], SYNC + 1);
    check_eq("gap_entered", pt, 6'b000000);
    reset_pulse();
    hold(3'b100, HALL_SEQ[1], 10);
    check_eq("gap_reset_latency", 6'(zero_cycles), 6'(SYNC));
    check_eq("gap_reset_pt", pt, 6'b100001);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ui = 3'($urandom);
        hs = 3'($urandom);
      end
      if ($urandom_range(0, 499) == 0) reset_pulse();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
